// File: rtl/sram_1rw_port_arbiter_if.sv
// Bundle of the two requester channels and the 1rw SRAM macro pins.
// slave  : arbiter side (takes requests, drives the macro pins).
// master : client/macro side (issues requests, returns dout0).
interface sram_1rw_port_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 2,
    parameter int NUM_WMASKS = 2
);
    // requester 0
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [NUM_WMASKS-1:0] req0_wmask;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    // requester 1
    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [NUM_WMASKS-1:0] req1_wmask;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    // SRAM macro pins (active-low controls)
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wmask,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wmask,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output csb0, web0, wmask0, addr0, din0,
        input  dout0
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_wmask,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_wmask,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  csb0, web0, wmask0, addr0, din0,
        output dout0
    );
endinterface

// File: rtl/sram_1rw_port_arbiter.sv
// Two-requester arbiter in front of a single 1rw write-masked SRAM macro.
// Grant is combinational; the acceptance edge is also the macro capture edge.
// Read data is steered back to the issuing requester through a {valid,id}
// tag pipeline that matches the macro read latency.
// Optional build macro: SRAM_ARB_FIXED_PRI_EN -- requester 0 gets strict
// priority instead of round-robin (requester 1 may starve).
// RD_LATENCY is meant to be in 1..4.
module sram_1rw_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 2,
    parameter int NUM_WMASKS = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_1rw_port_arbiter_if.slave bus
);

    logic                  grant_any;
    logic                  grant_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic                  write_cycle;

    logic [ADDR_WIDTH-1:0] addr_shadow_reg;
    logic [DATA_WIDTH-1:0] din_shadow_reg;

    // Tag stage k holds a read that has seen k edges after its capture edge;
    // the top stage is the cycle in which dout0 carries that read's data.
    logic [RD_LATENCY:0]   tag_valid_reg;
    logic [RD_LATENCY:0]   tag_id_reg;

`ifndef SRAM_ARB_FIXED_PRI_EN
    logic                  last_grant_reg;
`endif

    // Nothing is granted while reset is held, so readys and csb0 stay idle.
    assign grant_any = ~rst0 & (bus.req0_valid | bus.req1_valid);

    // Pick the winner: a lone requester always wins; contention is resolved
    // by priority or by alternating away from the last granted requester.
    always_comb begin
        grant_id = 1'b0;
`ifdef SRAM_ARB_FIXED_PRI_EN
        grant_id = ~bus.req0_valid;
`else
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = ~bus.req0_valid;
        end
`endif
    end

    // Route the winning requester's command towards the macro.
    always_comb begin
        sel_we    = bus.req0_we;
        sel_addr  = bus.req0_addr;
        sel_wdata = bus.req0_wdata;
        sel_wmask = bus.req0_wmask;
        if (grant_id) begin
            sel_we    = bus.req1_we;
            sel_addr  = bus.req1_addr;
            sel_wdata = bus.req1_wdata;
            sel_wmask = bus.req1_wmask;
        end
    end

    assign write_cycle    = grant_any & sel_we;

    assign bus.req0_ready = grant_any & ~grant_id;
    assign bus.req1_ready = grant_any &  grant_id;

    assign bus.csb0   = ~grant_any;
    assign bus.web0   = ~write_cycle;
    assign bus.wmask0 = write_cycle ? sel_wmask : '0;
    // Address/data pins keep their last driven value when idle, which avoids
    // needless toggling on the macro inputs.
    assign bus.addr0  = grant_any ? sel_addr  : addr_shadow_reg;
    assign bus.din0   = grant_any ? sel_wdata : din_shadow_reg;

    // Remember the last values driven onto addr0/din0.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            addr_shadow_reg <= '0;
            din_shadow_reg  <= '0;
        end else if (grant_any) begin
            addr_shadow_reg <= sel_addr;
            din_shadow_reg  <= sel_wdata;
        end
    end

`ifndef SRAM_ARB_FIXED_PRI_EN
    // Track who was accepted last; reset value makes requester 0 win first.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            last_grant_reg <= 1'b1;
        end else if (grant_any) begin
            last_grant_reg <= grant_id;
        end
    end
`endif

    // Shift read tags along with the macro latency; reset drops in-flight reads.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[RD_LATENCY-1:0], grant_any & ~sel_we};
            tag_id_reg    <= {tag_id_reg[RD_LATENCY-1:0], grant_id};
        end
    end

    assign bus.rsp0_valid = tag_valid_reg[RD_LATENCY] & ~tag_id_reg[RD_LATENCY];
    assign bus.rsp1_valid = tag_valid_reg[RD_LATENCY] &  tag_id_reg[RD_LATENCY];
    assign bus.rsp0_rdata = bus.rsp0_valid ? bus.dout0 : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? bus.dout0 : '0;

endmodule

// File: tb/tb_sram_1rw_port_arbiter.sv
// Directed bench for sram_1rw_port_arbiter with a behavioural 1rw masked SRAM.
// Build with SRAM_ARB_FIXED_PRI_EN defined to exercise the fixed-priority build.
module tb_sram_1rw_port_arbiter;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 2;
    localparam int NUM_WMASKS = 2;
    localparam int RD_LATENCY = 1;
    localparam int LANE_W     = DATA_WIDTH / NUM_WMASKS;

    logic clk0 = 1'b0;
    logic rst0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk0 = ~clk0;

    sram_1rw_port_arbiter_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS)
    ) bus ();

    sram_1rw_port_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .NUM_WMASKS(NUM_WMASKS), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus)
    );

    // Behavioural macro: capture on the edge where csb0 is low, read data
    // appears on dout0 after RD_LATENCY further edges.
    logic [DATA_WIDTH-1:0] mem     [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_pipe [0:RD_LATENCY];

    always @(posedge clk0) begin
        if (!bus.csb0 && !bus.web0) begin
            for (int l = 0; l < NUM_WMASKS; l++) begin
                if (bus.wmask0[l]) begin
                    mem[bus.addr0][l*LANE_W +: LANE_W] <= bus.din0[l*LANE_W +: LANE_W];
                end
            end
        end
        rd_pipe[0] <= (!bus.csb0 && bus.web0) ? mem[bus.addr0] : 'x;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign bus.dout0 = rd_pipe[RD_LATENCY];

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0;
        bus.req0_wdata = '0;   bus.req0_wmask = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0;
        bus.req1_wdata = '0;   bus.req1_wmask = '0;
    endtask

    task automatic drive_req0(input logic we, input logic [3:0] addr,
                              input logic [1:0] wdata, input logic [1:0] wmask);
        bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = addr;
        bus.req0_wdata = wdata; bus.req0_wmask = wmask;
        $display("[TB] t=%0t req0 %s addr=%h wdata=%b wmask=%b", $time,
                 we ? "write" : "read ", addr, wdata, wmask);
    endtask

    task automatic drive_req1(input logic we, input logic [3:0] addr,
                              input logic [1:0] wdata, input logic [1:0] wmask);
        bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = addr;
        bus.req1_wdata = wdata; bus.req1_wmask = wmask;
        $display("[TB] t=%0t req1 %s addr=%h wdata=%b wmask=%b", $time,
                 we ? "write" : "read ", addr, wdata, wmask);
    endtask

    // Reset with commands pending: nothing is granted, pins are idle and zeroed.
    task automatic test_reset();
        rst0 = 1'b1;
        drive_req0(1'b0, 4'h5, 2'b11, 2'b11);
        drive_req1(1'b1, 4'h6, 2'b11, 2'b11);
        tick();
        tick();
        tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req0_ready: got %b want 0", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req1_ready: got %b want 0", bus.req1_ready); end
        tests_run++; if (bus.csb0 !== 1'b1) begin tests_failed++; $display("FAIL rst_csb0: got %b want 1", bus.csb0); end
        tests_run++; if (bus.web0 !== 1'b1) begin tests_failed++; $display("FAIL rst_web0: got %b want 1", bus.web0); end
        tests_run++; if (bus.wmask0 !== 2'b00) begin tests_failed++; $display("FAIL rst_wmask0: got %b want 00", bus.wmask0); end
        tests_run++; if (bus.addr0 !== 4'h0) begin tests_failed++; $display("FAIL rst_addr0: got %h want 0", bus.addr0); end
        tests_run++; if (bus.din0 !== 2'b00) begin tests_failed++; $display("FAIL rst_din0: got %b want 00", bus.din0); end
        tests_run++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b%b want 00", bus.rsp0_valid, bus.rsp1_valid); end
        drive_idle();
        tick();
        rst0 = 1'b0;
        tick();
    endtask

    // Masked write of lane 1, then a read of the same address on the next cycle.
    task automatic test_masked_write_read();
        drive_req0(1'b1, 4'h1, 2'b10, 2'b10);
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL mwr_ready: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.csb0 !== 1'b0) begin tests_failed++; $display("FAIL mwr_csb0: got %b want 0", bus.csb0); end
        tests_run++; if (bus.web0 !== 1'b0) begin tests_failed++; $display("FAIL mwr_web0: got %b want 0", bus.web0); end
        tests_run++; if (bus.wmask0 !== 2'b10) begin tests_failed++; $display("FAIL mwr_wmask0: got %b want 10", bus.wmask0); end
        tests_run++; if (bus.addr0 !== 4'h1) begin tests_failed++; $display("FAIL mwr_addr0: got %h want 1", bus.addr0); end
        tests_run++; if (bus.din0 !== 2'b10) begin tests_failed++; $display("FAIL mwr_din0: got %b want 10", bus.din0); end
        tick();
        drive_req0(1'b0, 4'h1, 2'b00, 2'b11);
        #1;
        tests_run++; if (bus.web0 !== 1'b1) begin tests_failed++; $display("FAIL mrd_web0: got %b want 1", bus.web0); end
        tests_run++; if (bus.wmask0 !== 2'b00) begin tests_failed++; $display("FAIL mrd_wmask0: got %b want 00", bus.wmask0); end
        tests_run++; if (bus.csb0 !== 1'b0) begin tests_failed++; $display("FAIL mrd_csb0: got %b want 0", bus.csb0); end
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL mwr_no_rsp: got %b want 0", bus.rsp0_valid); end
        tick();
        drive_idle();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL mrd_early_rsp: got %b want 0", bus.rsp0_valid); end
        tests_run++; if (bus.csb0 !== 1'b1) begin tests_failed++; $display("FAIL mrd_idle_csb0: got %b want 1", bus.csb0); end
        tests_run++; if (bus.addr0 !== 4'h1) begin tests_failed++; $display("FAIL mrd_addr_hold: got %h want 1", bus.addr0); end
        tick();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL mrd_rsp_valid: got %b want 1", bus.rsp0_valid); end
        tests_run++; if (bus.rsp0_rdata[1] !== 1'b1) begin tests_failed++; $display("FAIL mrd_rdata_lane1: got %b want 1", bus.rsp0_rdata[1]); end
        tests_run++; if (bus.rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL mrd_rsp1_quiet: got %b want 0", bus.rsp1_valid); end
        tick();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL mrd_rsp_one_cycle: got %b want 0", bus.rsp0_valid); end
        tests_run++; if (bus.rsp0_rdata !== 2'b00) begin tests_failed++; $display("FAIL mrd_rdata_zero: got %b want 00", bus.rsp0_rdata); end
    endtask

    // Three idle cycles keep the macro deselected; then read a never-written word.
    task automatic test_idle_unwritten();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (bus.csb0 !== 1'b1) begin tests_failed++; $display("FAIL idle_csb0[%0d]: got %b want 1", c, bus.csb0); end
            tests_run++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_ready[%0d]: got %b%b want 00", c, bus.req0_ready, bus.req1_ready); end
            tick();
        end
        drive_req0(1'b0, 4'h0, 2'b00, 2'b00);
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL unw_ready: got %b want 1", bus.req0_ready); end
        tick();
        drive_idle();
        tick();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL unw_rsp0_valid: got %b want 1", bus.rsp0_valid); end
        tests_run++; if (bus.rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL unw_rsp1_valid: got %b want 0", bus.rsp1_valid); end
        tick();
    endtask

`ifdef SRAM_ARB_FIXED_PRI_EN
    // Requester 0 keeps winning while it is valid; requester 1 waits.
    task automatic test_fixed_priority();
        drive_req0(1'b0, 4'hC, 2'b00, 2'b00);
        drive_req1(1'b0, 4'h1, 2'b00, 2'b00);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL fp_req0_ready[%0d]: got %b want 1", c, bus.req0_ready); end
            tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL fp_req1_ready[%0d]: got %b want 0", c, bus.req1_ready); end
            tick();
        end
        bus.req0_valid = 1'b0;
        #1;
        tests_run++; if (bus.req1_ready !== 1'b1) begin tests_failed++; $display("FAIL fp_req1_after: got %b want 1", bus.req1_ready); end
        tick();
        drive_idle();
        tick();
        tick();
    endtask
`else
    // Both hold reads for four cycles: grants alternate and data is steered back.
    task automatic test_round_robin();
        logic exp_r0;
        logic exp_r1;
        drive_req0(1'b1, 4'hC, 2'b10, 2'b11);
        tick();
        drive_idle();
        drive_req1(1'b1, 4'h1, 2'b01, 2'b11);
        tick();
        drive_idle();
        drive_req0(1'b0, 4'hC, 2'b00, 2'b00);
        drive_req1(1'b0, 4'h1, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) drive_idle();
            #1;
            exp_r0 = (k >= 2) && ((k % 2) == 0);
            exp_r1 = (k >= 2) && ((k % 2) == 1);
            if (k < 4) begin
                tests_run++; if (bus.req0_ready !== ((k % 2) == 0)) begin tests_failed++; $display("FAIL rr_req0_ready[%0d]: got %b want %b", k, bus.req0_ready, ((k % 2) == 0)); end
                tests_run++; if (bus.req1_ready !== ((k % 2) == 1)) begin tests_failed++; $display("FAIL rr_req1_ready[%0d]: got %b want %b", k, bus.req1_ready, ((k % 2) == 1)); end
                tests_run++; if (bus.addr0 !== (((k % 2) == 0) ? 4'hC : 4'h1)) begin tests_failed++; $display("FAIL rr_addr0[%0d]: got %h", k, bus.addr0); end
            end
            tests_run++; if (bus.rsp0_valid !== exp_r0) begin tests_failed++; $display("FAIL rr_rsp0_valid[%0d]: got %b want %b", k, bus.rsp0_valid, exp_r0); end
            tests_run++; if (bus.rsp1_valid !== exp_r1) begin tests_failed++; $display("FAIL rr_rsp1_valid[%0d]: got %b want %b", k, bus.rsp1_valid, exp_r1); end
            tests_run++; if (bus.rsp0_rdata !== (exp_r0 ? 2'b10 : 2'b00)) begin tests_failed++; $display("FAIL rr_rsp0_rdata[%0d]: got %b", k, bus.rsp0_rdata); end
            tests_run++; if (bus.rsp1_rdata !== (exp_r1 ? 2'b01 : 2'b00)) begin tests_failed++; $display("FAIL rr_rsp1_rdata[%0d]: got %b", k, bus.rsp1_rdata); end
            tick();
        end
    endtask
`endif

    // Two partial writes from different requesters merge into one word.
    task automatic test_write_mask_merge();
        drive_idle();
        drive_req1(1'b1, 4'hC, 2'b01, 2'b01);
        #1;
        tests_run++; if (bus.wmask0 !== 2'b01) begin tests_failed++; $display("FAIL wm_wmask_r1: got %b want 01", bus.wmask0); end
        tests_run++; if (bus.din0 !== 2'b01) begin tests_failed++; $display("FAIL wm_din_r1: got %b want 01", bus.din0); end
        tick();
        drive_idle();
        drive_req0(1'b1, 4'hC, 2'b11, 2'b10);
        #1;
        tests_run++; if (bus.wmask0 !== 2'b10) begin tests_failed++; $display("FAIL wm_wmask_r0: got %b want 10", bus.wmask0); end
        tests_run++; if (bus.addr0 !== 4'hC) begin tests_failed++; $display("FAIL wm_addr_r0: got %h want c", bus.addr0); end
        tick();
        drive_idle();
        drive_req1(1'b0, 4'hC, 2'b00, 2'b00);
        #1;
        tests_run++; if (bus.req1_ready !== 1'b1) begin tests_failed++; $display("FAIL wm_rd_ready: got %b want 1", bus.req1_ready); end
        tests_run++; if (bus.wmask0 !== 2'b00) begin tests_failed++; $display("FAIL wm_rd_wmask: got %b want 00", bus.wmask0); end
        tick();
        drive_idle();
        #1;
        tests_run++; if (bus.rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL wm_early_rsp1: got %b want 0", bus.rsp1_valid); end
        tick();
        #1;
        tests_run++; if (bus.rsp1_valid !== 1'b1) begin tests_failed++; $display("FAIL wm_rsp1_valid: got %b want 1", bus.rsp1_valid); end
        tests_run++; if (bus.rsp1_rdata !== 2'b11) begin tests_failed++; $display("FAIL wm_rsp1_rdata: got %b want 11", bus.rsp1_rdata); end
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL wm_rsp0_quiet: got %b want 0", bus.rsp0_valid); end
        tick();
    endtask

    // Reset right after a read is accepted: the response must never appear,
    // and requester 0 wins the first contention afterwards.
    task automatic test_reset_mid_read();
        drive_idle();
        drive_req0(1'b0, 4'hC, 2'b00, 2'b00);
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL rmr_accept: got %b want 1", bus.req0_ready); end
        tick();
        rst0 = 1'b1;
        drive_req1(1'b0, 4'h1, 2'b00, 2'b00);
        #1;
        tests_run++; if (bus.req0_ready !== 1'b0) begin tests_failed++; $display("FAIL rmr_req0_ready: got %b want 0", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rmr_req1_ready: got %b want 0", bus.req1_ready); end
        tests_run++; if (bus.csb0 !== 1'b1) begin tests_failed++; $display("FAIL rmr_csb0: got %b want 1", bus.csb0); end
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL rmr_rsp0_a: got %b want 0", bus.rsp0_valid); end
        tick();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL rmr_rsp0_b: got %b want 0", bus.rsp0_valid); end
        tests_run++; if (bus.rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL rmr_rsp1_b: got %b want 0", bus.rsp1_valid); end
        drive_idle();
        tick();
        rst0 = 1'b0;
        tick();
        #1;
        tests_run++; if (bus.rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL rmr_rsp0_c: got %b want 0", bus.rsp0_valid); end
        drive_req0(1'b0, 4'hC, 2'b00, 2'b00);
        drive_req1(1'b0, 4'h1, 2'b00, 2'b00);
        #1;
        tests_run++; if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL rmr_first_win0: got %b want 1", bus.req0_ready); end
        tests_run++; if (bus.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rmr_first_win1: got %b want 0", bus.req1_ready); end
        tick();
        drive_idle();
        tick();
    endtask

    initial begin
        rst0 = 1'b1;
        drive_idle();
        test_reset();
        test_masked_write_read();
        test_idle_unwritten();
`ifdef SRAM_ARB_FIXED_PRI_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_write_mask_merge();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_1rw_port_arbiter.md
Name: sram_1rw_port_arbiter

Overview:
- Shares one 1rw write-masked SRAM macro (csb0/web0/wmask0 style, active-low controls) between two requesters.
- Each requester has a valid/ready request channel and an unstalled response channel.
- Arbitration is round-robin by default.
- Read data is routed back to the requester that issued the read, after a fixed macro read latency.
- Sits between client logic and the generated SRAM instance; the macro itself is unchanged.

Parameters:
- ADDR_WIDTH, 4, SRAM address bits.
- DATA_WIDTH, 2, SRAM word width.
- NUM_WMASKS, 2, write-mask bits; DATA_WIDTH must be divisible by NUM_WMASKS, each bit covers DATA_WIDTH/NUM_WMASKS bits.
- RD_LATENCY, 1, number of clk0 edges from read capture to dout0 valid; legal range 1..4.

Ports:
- clk0  in  1  clock, shared with the SRAM macro
- rst0  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this edge
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_WIDTH  address
- req0_wdata  in  DATA_WIDTH  write data
- req0_wmask  in  NUM_WMASKS  write byte-lane mask
- rsp0_valid  out  1  read data valid for requester 0
- rsp0_rdata  out  DATA_WIDTH  read data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, req1_wmask, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
- csb0  out  1  SRAM chip select, active-low
- web0  out  1  SRAM write enable, active-low
- wmask0  out  NUM_WMASKS  SRAM write mask
- addr0  out  ADDR_WIDTH  SRAM address
- din0  out  DATA_WIDTH  SRAM write data
- dout0  in  DATA_WIDTH  SRAM read data

Behaviour:
- Arbitration is combinational within the cycle. grant = winner among asserted reqN_valid; reqN_ready = grant to N; at most one ready is high per cycle.
- Acceptance edge = edge where valid&ready are high. That same edge is the SRAM capture edge.
- SRAM drive while a grant is active:
  - csb0 = 0.
  - web0 = ~reqN_we.
  - addr0 and din0 come from the granted requester.
  - wmask0 = reqN_wmask on writes, all-zero on reads.
- No grant: csb0 = 1, web0 = 1, wmask0 = 0; addr0 and din0 hold their last driven values (registered shadow).
- Round-robin: a 1-bit last_grant register updates on each acceptance.
  - When both are valid, the requester not equal to last_grant wins.
  - When only one is valid, it wins regardless of last_grant.
- Read return uses a tag pipeline, RD_LATENCY deep, of {valid, id}, pushed on every accepted read.
  - rspN_valid = 1 during exactly one cycle: the cycle following the RD_LATENCY-th edge after acceptance, with id == N.
  - rspN_rdata = dout0 while rspN_valid is high; otherwise rspN_rdata is driven to 0.
- Back-to-back reads from alternating or identical requesters are supported every cycle. Responses return in issue order, with no stall.
- Writes produce no response. A read issued one cycle after a write to the same address returns the written lanes; unwritten lanes keep their prior value (X if never written).
- Reset (rst0 high, any time including mid-read):
  - Both readys = 0; csb0 = 1, web0 = 1, wmask0 = 0; addr0 = 0, din0 = 0.
  - Tag pipeline is cleared, so in-flight reads are dropped and no rspN_valid is ever raised for them.
  - last_grant = 1, so requester 0 wins the first contention.
- Valid held without ready: the requester must hold its command stable. The arbiter makes no assumption about deassertion.

Optional Feature:
- SRAM_ARB_FIXED_PRI_EN.
- Defined: requester 0 has strict priority whenever req0_valid is high, and last_grant is not used. Requester 1 may starve, which is permitted.
- Undefined: round-robin exactly as specified above.

Test Plan:
- Reset mid-read: with RD_LATENCY=1, assert rst0 one cycle after a req0 read is accepted. Required: rsp0_valid never asserts, csb0 = 1, req0_ready = 0 during reset.
- Masked write then read: req0 writes addr 1, data 2'b10, wmask 2'b10. Next cycle req0 reads addr 1. Required: rsp0_valid for one cycle with rsp0_rdata = 2'b1x, and during the write cycle csb0 = 0, web0 = 0, wmask0 = 2'b10.
- Contention round-robin: both requesters hold reads valid for 4 cycles (req0 addr 4'hC, req1 addr 4'h1). Required: grants alternate 0,1,0,1, and each rspN_valid returns its own address's data one cycle after acceptance.
- Write-mask merge: req1 writes addr 4'hC, 2'b01, mask 2'b01; req0 writes addr 4'hC, 2'b11, mask 2'b10; req1 reads addr 4'hC. Required: rsp1_rdata = 2'b11, and rsp0_valid stays low.
- Idle and unwritten read: no valids for 3 cycles, then csb0 = 1 throughout. A req0 read of addr 0 (never written) then gives rsp0_rdata = 2'bxx with rsp0_valid = 1.
- Fixed priority (SRAM_ARB_FIXED_PRI_EN defined): both valid for 3 cycles. Required: req0_ready = 1 on all 3 cycles and req1_ready = 0 until req0_valid drops.
